// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the MEM-stage load/store unit.
// Holds the datapath width, the LSU handshake state type and the
// Funct3 encodings for memory access size and sign.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory bus between the load/store unit and a single-port memory.
// master: the LSU (drives request, write enable, address, byte enables,
//         store data; receives grant, read-valid and read data).
// slave : the memory side.
interface mem_lsu_if #(
    parameter int XLEN = riscv_pkg::XLEN
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [3:0]      dmem_be;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_lsu_load_align.sv
// Combinational load-data alignment: picks the addressed byte/halfword
// out of the raw memory word and sign- or zero-extends it.
// Ports:
//   i_addr_lo  low two address bits (byte offset within the word)
//   i_funct3   access size/sign (LB/LH/LW/LBU/LHU)
//   i_raw      raw word returned by memory
//   o_data     extended load value
module lsu_load_align
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [1:0]      i_addr_lo,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_raw,
    output logic [XLEN-1:0] o_data
);

    logic signed [7:0]  w_byte;
    logic signed [15:0] w_half;

    assign w_byte = i_raw[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_raw[31:16] : i_raw[15:0];

    always_comb begin
        o_data = '0;
        case (i_funct3)
            F3_B:    o_data = XLEN'(w_byte);
            F3_H:    o_data = XLEN'(w_half);
            F3_W:    o_data = i_raw;
            F3_BU:   o_data = XLEN'($unsigned(w_byte));
            F3_HU:   o_data = XLEN'($unsigned(w_half));
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit for the RV32I pipeline.
// Issues one request/grant/response transaction per aligned memory op,
// forms byte enables and replicated store data, extends load data, and
// stalls the front of the pipeline until the access completes. Misaligned
// ops are dropped (no request) and flagged with a one-cycle MisalignM.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   EXMEM_valid, MemReadM,
//   MemWriteM, Funct3M,
//   RegWriteM, ALUResultM,
//   WriteDataM               instruction fields from EX/MEM
//   dmem                     data-memory bus (master side)
//   ReadDataM                extended load data to MEM/WB
//   LsuStallM                hold PC, IF/ID, ID/EX and EX/MEM
//   MemValidM, RegWriteMemM  valid and gated RegWrite into MEM/WB
//   MisalignM                misaligned-access pulse
module mem_lsu
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            EXMEM_valid,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic [2:0]      Funct3M,
    input  logic            RegWriteM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    mem_lsu_if.master       dmem,
    output logic [XLEN-1:0] ReadDataM,
    output logic            LsuStallM,
    output logic            MemValidM,
    output logic            RegWriteMemM,
    output logic            MisalignM
);

    function automatic logic [3:0] f_byte_en(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] f_store_data(input logic [2:0] f3, input logic [XLEN-1:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    lsu_state_t      r_state;
    lsu_state_t      w_state_nxt;
    logic [XLEN-1:0] r_rdata_q;

    logic            w_memop;
    logic            w_misalign;
    logic            w_issue;
    logic            w_req;
    logic            w_stall;
    logic            w_capture;
    logic [XLEN-1:0] w_load_ext;

    assign w_memop    = EXMEM_valid & (MemReadM | MemWriteM);
    assign w_misalign = w_memop &
                        (((Funct3M[1:0] == 2'b01) & ALUResultM[0]) |
                         ((Funct3M[1:0] == 2'b10) & (|ALUResultM[1:0])));
    assign w_issue    = w_memop & ~w_misalign;

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE, REQ: begin
                // REQ is only reachable by an aligned op held in EX/MEM.
                if (w_issue || r_state == REQ) begin
                    w_req   = 1'b1;
                    w_stall = 1'b1;
                    if (dmem.dmem_gnt)
                        w_state_nxt = MemWriteM ? DONE : WAIT;
                    else
                        w_state_nxt = REQ;
                end
            end
            WAIT: begin
                w_stall = 1'b1;
                if (dmem.dmem_rvalid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rdata_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture)
                r_rdata_q <= dmem.dmem_rdata;
        end
    end

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .i_addr_lo (ALUResultM[1:0]),
        .i_funct3  (Funct3M),
        .i_raw     (r_rdata_q),
        .o_data    (w_load_ext)
    );

    // Outputs are forced low while rst is high so the bus and MEM/WB see
    // a quiet, bubble-only interface during reset.
    assign LsuStallM    = w_stall & ~rst;
    assign MisalignM    = (r_state == IDLE) & w_misalign & ~rst;
    assign MemValidM    = EXMEM_valid & ~LsuStallM & ~MisalignM & ~rst;
    assign RegWriteMemM = RegWriteM & MemValidM;
    assign ReadDataM    = (!rst && r_state == DONE && MemReadM) ? w_load_ext : '0;

    // Bus fields follow the held EX/MEM values, so they stay stable while
    // a request waits for its grant.
    assign dmem.dmem_req   = w_req & ~rst;
    assign dmem.dmem_we    = dmem.dmem_req & MemWriteM;
    assign dmem.dmem_addr  = dmem.dmem_req ? {ALUResultM[XLEN-1:2], 2'b00} : '0;
    assign dmem.dmem_be    = dmem.dmem_req ? f_byte_en(Funct3M, ALUResultM[1:0]) : 4'b0000;
    assign dmem.dmem_wdata = dmem.dmem_we ? f_store_data(Funct3M, WriteDataM) : '0;

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit for the MEM stage of the RV32I pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register. Runs a request/grant/response handshake with a single-port data memory, generates byte enables and store-data replication, and sign/zero-extends load data. Stalls the front of the pipeline while an access is outstanding and emits a bubble (valid = 0) into MEM/WB until the access completes.

## Interface
Parameters:
- XLEN, default riscv_pkg::XLEN (32): datapath width; the block supports 32 only.

Ports (clock and reset first; one clock domain; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- EXMEM_valid  in  1  instruction present in MEM.
- MemReadM  in  1  load.
- MemWriteM  in  1  store.
- Funct3M  in  3  access size/sign (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101).
- RegWriteM  in  1  write-back enable from EX/MEM.
- ALUResultM  in  XLEN  effective address.
- WriteDataM  in  XLEN  store data (rs2).
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  XLEN  word-aligned address {ALUResultM[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  XLEN  replicated store data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  XLEN  raw load word.
- ReadDataM  out  XLEN  extended load data, to MEM/WB.
- LsuStallM  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- MemValidM  out  1  valid into MEM/WB.
- RegWriteMemM  out  1  gated RegWrite into MEM/WB.
- MisalignM  out  1  misaligned-access pulse.

## Operation
- Memop = EXMEM_valid & (MemReadM | MemWriteM). Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
- FSM states (lsu_state_t): IDLE, REQ, WAIT, DONE.
  - IDLE: an aligned memop drives dmem_req=1 and LsuStallM=1. On dmem_gnt, a store goes to DONE and a load goes to WAIT; without gnt, go to REQ. Non-memops and misaligned ops stay in IDLE without stalling.
  - REQ: dmem_req=1, LsuStallM=1. Transitions on gnt are the same as in IDLE.
  - WAIT: dmem_req=0, LsuStallM=1. On dmem_rvalid, capture dmem_rdata into rdata_q and go to DONE.
  - DONE: LsuStallM=0. ReadDataM is taken from rdata_q. Return to IDLE next cycle.
- MemValidM = EXMEM_valid & ~LsuStallM & ~MisalignM. RegWriteMemM = RegWriteM & MemValidM.
- Misaligned op: no request is issued. MisalignM=1 for the single cycle the op sits in MEM. No stall. The op retires as a bubble: no store and no register write.
- Byte enables: SB gives 4'b0001<<addr[1:0]; SH gives 4'b0011<<addr[1:0]; SW gives 4'b1111.
- Store data: SB replicates wdata byte ×4; SH replicates halfword ×2; SW passes through.
- Load: select the byte or halfword by addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU). LW passes through.
- For a non-memop, ReadDataM = 0.
- dmem_rvalid outside WAIT and dmem_gnt outside IDLE/REQ are ignored.

## Timing
- Reset values:
  - State: IDLE.
  - rdata_q: 0.
  - All outputs: 0 (dmem_req, dmem_we, dmem_be, LsuStallM, MemValidM, RegWriteMemM, MisalignM, ReadDataM).
- Store with same-cycle gnt: 2 cycles in MEM (IDLE/REQ, then DONE).
- Load with gnt plus next-cycle rvalid: 3 cycles in MEM.
- Each extra cycle without gnt, or waiting for rvalid, adds one cycle.
- dmem_addr, dmem_be, dmem_wdata and dmem_we are stable while dmem_req=1 and gnt=0, because EX/MEM is held.
- Back-to-back memops: the next op enters IDLE the cycle after DONE; at most one request per 2 cycles.
- gnt→LsuStallM is combinational only through the next-state logic; LsuStallM is a function of state and inputs, not of rvalid.
- Reset mid-access: return to IDLE and drop req. A late rvalid after reset is ignored.

## Structure
- riscv_pkg holds:
  - lsu_state_t
  - Funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
- Sub-module lsu_load_align (combinational): addr[1:0], Funct3M, raw word → extended data. It is reused for both the DONE path and unit test.

## Test plan
- SW to 0x100 with data 0xDEADBEEF and gnt in the same cycle → dmem_be=1111, wdata=0xDEADBEEF, stall for 1 cycle, MemValidM=1 in DONE, RegWriteMemM=0.
- LB from 0x103 with rdata 0x80FF_0000 and rvalid one cycle after gnt → ReadDataM=0xFFFFFF80, LsuStallM high 2 cycles.
- LBU from the same address and data → ReadDataM=0x00000080. LHU from 0x102 → ReadDataM=0x000080FF.
- gnt withheld 3 cycles on SH to 0x102 with data 0x1234 → dmem_req held 4 cycles, addr/be=1100/wdata=0x12341234 stable throughout, one write.
- LW to 0x101 → no dmem_req, MisalignM=1 for one cycle, MemValidM=0, no stall.
- rst asserted while in WAIT, with rvalid arriving on the following cycle → state IDLE, all outputs 0, rdata ignored.
